// File: rtl/dmem_arbiter.sv
// Purpose : shares the single-port data_memory between the CPU load/store port and the debug/loader port.
//           The CPU has fixed priority. After MAX_WAIT consecutive lost arbitrations the debug port gets a forced grant.
// Latency : request sampled at edge E, memory access in cycle E..E+1, ack pulse in cycle E+1..E+2.
// Backpres: a requester holds req and its fields until its ack; there is at most one access every 2 cycles.
// Ports   : cpu_* / dbg_* are the req/we/addr/wdata inputs and ack/rdata outputs of each requester;
//           mem_we/mem_addr/mem_wdata/mem_rdata connect to WE_dmem/alu_out/reg_out/mem_out;
//           busy is high in ACCESS; owner gives the port of the current or last access (0 = CPU, 1 = debug).
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              owner_q, owner_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic dbg_forced;
    logic grant_dbg;
    logic grant_cpu;

    always_comb begin
        // The debug port overrides the CPU only once it has lost MAX_WAIT arbitrations in a row.
        dbg_forced = dbg_req && (wait_cnt_q == WAIT_MAX);
        grant_dbg  = dbg_forced || (dbg_req && !cpu_req);
        grant_cpu  = cpu_req && !dbg_forced;

        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_dbg) begin
                    mem_we_d    = dbg_we;
                    mem_addr_d  = dbg_addr;
                    mem_wdata_d = dbg_wdata;
                    owner_d     = 1'b1;
                    wait_cnt_d  = 4'd0;
                    state_d     = ACCESS;
                end else if (grant_cpu) begin
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    owner_d     = 1'b0;
                    state_d     = ACCESS;
                    if (!dbg_req) begin
                        wait_cnt_d = 4'd0;
                    end else if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else if (!dbg_req) begin
                    wait_cnt_d = 4'd0;
                end
            end
            ACCESS: begin
                // mem_* were stable through this cycle, so a write commits at this closing edge.
                mem_we_d = 1'b0;
                state_d  = IDLE;
                if (owner_q) begin
                    dbg_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        dbg_rdata_d = mem_rdata;
                    end
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Asynchronous reset drops mem_we immediately, so an in-flight write never commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign busy      = (state_q == ACCESS);
    assign owner     = owner_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : self-checking bench for dmem_arbiter with a behavioural data_memory and a reference memory image.
// Latency : stimulus is driven and outputs are sampled on the falling clock edge.
// Backpres: requests are held until ack; every wait is bounded by a cycle budget.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0, dbg_wdata = '0;
    logic        cpu_ack, dbg_ack, mem_we, busy, owner;
    logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cpu_ack_cnt = 0;
    int dbg_ack_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    // data_memory: combinational read, write on the rising edge; preloaded with addr & 0x6976.
    logic [15:0] mem [0:65535];
    logic        mem_init = 1'b0;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) & 16'h6976;
            mem_init <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference image of what the memory must contain.
    logic [15:0] exp_mem [0:65535];

    always @(negedge clk) begin
        if (cpu_ack) cpu_ack_cnt++;
        if (dbg_ack) dbg_ack_cnt++;
    end

    task automatic cpu_txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                           output int cyc, output logic [15:0] rd, output logic own);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        cyc = -1; rd = '0; own = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cyc = i; rd = cpu_rdata; own = owner;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic dbg_txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                           output int cyc, output logic [15:0] rd, output logic own);
        dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
        cyc = -1; rd = '0; own = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (dbg_ack) begin
                cyc = i; rd = dbg_rdata; own = owner;
                break;
            end
        end
        dbg_req = 1'b0;
    endtask

    task automatic test_reset;
        // A pending request during reset must not produce any activity.
        cpu_req = 1'b1; cpu_addr = 16'h5555; cpu_wdata = 16'h1111; cpu_we = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_we, cpu_ack, dbg_ack, busy, owner} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {mem_we, cpu_ack, dbg_ack, busy, owner});
        end
        total++;
        if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== 64'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dbg_rdata});
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_dbg_write_read;
        int cyc; logic [15:0] rd; logic own; int c0;
        c0 = cpu_ack_cnt;
        dbg_txn(1'b1, 16'h0010, 16'hBEEF, cyc, rd, own);
        exp_mem[16'h0010] = 16'hBEEF;
        total++;
        if (cyc !== 2) begin bad++; $display("FAIL dbg_wr_lat: got %0d want 2", cyc); end
        @(negedge clk);
        total++;
        if (dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_ack_width: got %b want 0", dbg_ack); end
        dbg_txn(1'b0, 16'h0010, 16'h0000, cyc, rd, own);
        total++;
        if (cyc !== 2) begin bad++; $display("FAIL dbg_rd_lat: got %0d want 2", cyc); end
        total++;
        if (rd !== exp_mem[16'h0010]) begin bad++; $display("FAIL dbg_rd_data: got %h want %h", rd, exp_mem[16'h0010]); end
        total++;
        if (cpu_ack_cnt !== c0) begin bad++; $display("FAIL dbg_no_cpu_ack: got %0d want %0d", cpu_ack_cnt, c0); end
    endtask

    task automatic test_simultaneous;
        int ccyc, dcyc; logic [15:0] crd, drd; logic cown, down;
        fork
            cpu_txn(1'b0, 16'h0020, 16'h0000, ccyc, crd, cown);
            dbg_txn(1'b0, 16'h0030, 16'h0000, dcyc, drd, down);
        join
        total++;
        if (ccyc !== 2) begin bad++; $display("FAIL sim_cpu_lat: got %0d want 2", ccyc); end
        total++;
        if (crd !== exp_mem[16'h0020]) begin bad++; $display("FAIL sim_cpu_data: got %h want %h", crd, exp_mem[16'h0020]); end
        total++;
        if (cown !== 1'b0) begin bad++; $display("FAIL sim_cpu_owner: got %b want 0", cown); end
        total++;
        if (dcyc !== 4) begin bad++; $display("FAIL sim_dbg_lat: got %0d want 4", dcyc); end
        total++;
        if (drd !== exp_mem[16'h0030]) begin bad++; $display("FAIL sim_dbg_data: got %h want %h", drd, exp_mem[16'h0030]); end
        total++;
        if (down !== 1'b1) begin bad++; $display("FAIL sim_dbg_owner: got %b want 1", down); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_starvation;
        logic got [10];
        int n; int lost; logic exp_o;
        n = 0;
        cpu_we = 1'b0; cpu_addr = 16'h0040; dbg_we = 1'b0; dbg_addr = 16'h0050;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 60 && n < 10; i++) begin
            @(negedge clk);
            if (busy) begin got[n] = owner; n++; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        total++;
        if (n !== 10) begin bad++; $display("FAIL starve_grants: got %0d want 10", n); end
        // Debug loses until it has lost MW times in a row, then wins once.
        lost = 0;
        for (int k = 0; k < n; k++) begin
            if (lost == MW) begin exp_o = 1'b1; lost = 0; end
            else begin exp_o = 1'b0; lost = lost + 1; end
            total++;
            if (got[k] !== exp_o) begin bad++; $display("FAIL starve_order[%0d]: got %b want %b", k, got[k], exp_o); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        int cyc; logic [15:0] rd; logic own; int c0;
        c0 = cpu_ack_cnt;
        cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 16'hAAAA; cpu_req = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, mem_we} !== 2'b11) begin bad++; $display("FAIL rst_pre_access: got %b want 11", {busy, mem_we}); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (cpu_ack_cnt !== c0) begin bad++; $display("FAIL rst_no_ack: got %0d want %0d", cpu_ack_cnt, c0); end
        total++;
        if (mem[16'h1234] !== exp_mem[16'h1234]) begin
            bad++; $display("FAIL rst_mem_kept: got %h want %h", mem[16'h1234], exp_mem[16'h1234]);
        end
        cpu_txn(1'b0, 16'h1234, 16'h0000, cyc, rd, own);
        total++;
        if (rd !== exp_mem[16'h1234]) begin bad++; $display("FAIL rst_readback: got %h want %h", rd, exp_mem[16'h1234]); end
    endtask

    task automatic test_back_to_back;
        int cyc; logic [15:0] rd; logic own; logic [15:0] a;
        int idx; int last; logic exp_b;
        for (int k = 0; k < 4; k++) begin
            a = 16'hFFFC + 16'(k);
            cpu_txn(1'b1, a, a & 16'h6976, cyc, rd, own);
            exp_mem[a] = a & 16'h6976;
            total++;
            if (cyc !== 2) begin bad++; $display("FAIL b2b_wr_lat[%0d]: got %0d want 2", k, cyc); end
        end
        idx = 0; last = 0;
        cpu_we = 1'b0; cpu_addr = 16'hFFFC; cpu_req = 1'b1;
        for (int i = 1; i <= 40 && idx < 4; i++) begin
            @(negedge clk);
            exp_b = (i % 2 == 1);
            total++;
            if (busy !== exp_b) begin bad++; $display("FAIL b2b_busy[%0d]: got %b want %b", i, busy, exp_b); end
            if (cpu_ack) begin
                a = 16'hFFFC + 16'(idx);
                total++;
                if (cpu_rdata !== exp_mem[a]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", idx, cpu_rdata, exp_mem[a]); end
                if (idx > 0) begin
                    total++;
                    if (i - last !== 2) begin bad++; $display("FAIL b2b_gap[%0d]: got %0d want 2", idx, i - last); end
                end
                last = i; idx++;
                if (idx < 4) cpu_addr = 16'hFFFC + 16'(idx);
                else cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        total++;
        if (idx !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", idx); end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({mem_we, busy, cpu_ack, dbg_ack} !== 4'b0) begin
                bad++; $display("FAIL idle_ctrl[%0d]: got %b want 0000", i, {mem_we, busy, cpu_ack, dbg_ack});
            end
            total++;
            if (mem_addr !== 16'hFFFF) begin bad++; $display("FAIL idle_addr[%0d]: got %h want ffff", i, mem_addr); end
        end
    endtask

    task automatic test_random;
        int ccyc, dcyc; logic [15:0] crd, drd; logic cown, down;
        logic cknown, dknown; logic [15:0] ecr, edr;
        int mode; logic cwe, dwe; logic [15:0] ca, da, cd, dd;
        cknown = 1'b0; dknown = 1'b0; ecr = '0; edr = '0;
        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 2));
            cwe = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
            ca = 16'h0100 + 16'($urandom_range(0, 15));
            da = 16'h0200 + 16'($urandom_range(0, 15));
            cd = 16'($urandom); dd = 16'($urandom);
            ccyc = 2; dcyc = 2; crd = ecr; drd = edr;
            if (mode == 0) cpu_txn(cwe, ca, cd, ccyc, crd, cown);
            else if (mode == 1) dbg_txn(dwe, da, dd, dcyc, drd, down);
            else begin
                fork
                    cpu_txn(cwe, ca, cd, ccyc, crd, cown);
                    dbg_txn(dwe, da, dd, dcyc, drd, down);
                join
            end
            if (mode != 1) begin
                total++;
                if (ccyc !== 2) begin bad++; $display("FAIL rnd_cpu_lat[%0d]: got %0d want 2", n, ccyc); end
                if (cwe) begin
                    exp_mem[ca] = cd;
                    if (cknown) begin
                        total++;
                        if (crd !== ecr) begin bad++; $display("FAIL rnd_cpu_wr_rdata[%0d]: got %h want %h", n, crd, ecr); end
                    end
                end else begin
                    total++;
                    if (crd !== exp_mem[ca]) begin bad++; $display("FAIL rnd_cpu_rd[%0d]: got %h want %h", n, crd, exp_mem[ca]); end
                    ecr = exp_mem[ca]; cknown = 1'b1;
                end
            end
            if (mode != 0) begin
                total++;
                if (dcyc !== (mode == 2 ? 4 : 2)) begin bad++; $display("FAIL rnd_dbg_lat[%0d]: got %0d", n, dcyc); end
                if (dwe) begin
                    exp_mem[da] = dd;
                    if (dknown) begin
                        total++;
                        if (drd !== edr) begin bad++; $display("FAIL rnd_dbg_wr_rdata[%0d]: got %h want %h", n, drd, edr); end
                    end
                end else begin
                    total++;
                    if (drd !== exp_mem[da]) begin bad++; $display("FAIL rnd_dbg_rd[%0d]: got %h want %h", n, drd, exp_mem[da]); end
                    edr = exp_mem[da]; dknown = 1'b1;
                end
            end
            // The port that was not served must keep its read data.
            if (mode == 0 && dknown) begin
                total++;
                if (dbg_rdata !== edr) begin bad++; $display("FAIL rnd_dbg_kept[%0d]: got %h want %h", n, dbg_rdata, edr); end
            end
            if (mode == 1 && cknown) begin
                total++;
                if (cpu_rdata !== ecr) begin bad++; $display("FAIL rnd_cpu_kept[%0d]: got %h want %h", n, cpu_rdata, ecr); end
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) exp_mem[i] = 16'(i) & 16'h6976;
        @(negedge clk);
        test_reset();
        test_dbg_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_access();
        test_back_to_back();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
